// File: rtl/sync_channel_arbiter.sv
// Round-robin arbiter sharing one slow-to-fast data synchronizer channel.
// Ports: clk, reset_n, req/req_data in; ack, bus_data/tag/valid/toggle, busy out.
module sync_channel_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 5,
   parameter int HOLD_CYCLES = 3
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         ack,
   output logic [DATA_W-1:0]          bus_data,
   output logic [$clog2(NUM_REQ)-1:0] bus_tag,
   output logic                       bus_valid,
   output logic                       bus_toggle,
   output logic                       busy
);

   localparam int TAG_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(HOLD_CYCLES);

   localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] CNT_ACK  = CNT_W'(HOLD_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_RELEASE
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   hold_cnt, cnt_nxt;
   logic [TAG_W-1:0]   last_grant, grant_nxt;
   logic [NUM_REQ-1:0] ack_nxt;
   logic [DATA_W-1:0]  data_nxt;
   logic [TAG_W-1:0]   tag_nxt;
   logic               valid_nxt;
   logic               tog_nxt;

   logic               win_found;
   logic [TAG_W-1:0]   win_idx;
   logic [TAG_W-1:0]   cand;

   // Search starts one past the last winner so every requester
   // gets a turn before anyone is served twice.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = TAG_W'((int'(last_grant) + i) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = hold_cnt;
      grant_nxt = last_grant;
      ack_nxt   = '0;
      data_nxt  = bus_data;
      tag_nxt   = bus_tag;
      valid_nxt = bus_valid;
      tog_nxt   = bus_toggle;
      unique case (state)
         S_IDLE: begin
            if (win_found) begin
               data_nxt  = req_data[int'(win_idx)*DATA_W +: DATA_W];
               tag_nxt   = win_idx;
               grant_nxt = win_idx;
               valid_nxt = 1'b1;
               tog_nxt   = ~bus_toggle;
               cnt_nxt   = '0;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (hold_cnt == CNT_END) begin
               valid_nxt = 1'b0;
               state_nxt = S_RELEASE;
            end else begin
               cnt_nxt = hold_cnt + CNT_W'(1);
               // ack lands on the last valid cycle
               if (hold_cnt == CNT_ACK)
                  ack_nxt[bus_tag] = 1'b1;
            end
         end
         S_RELEASE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         hold_cnt   <= '0;
         last_grant <= LAST_IDX;
         ack        <= '0;
         bus_data   <= '0;
         bus_tag    <= '0;
         bus_valid  <= 1'b0;
         bus_toggle <= 1'b0;
      end else begin
         state      <= state_nxt;
         hold_cnt   <= cnt_nxt;
         last_grant <= grant_nxt;
         ack        <= ack_nxt;
         bus_data   <= data_nxt;
         bus_tag    <= tag_nxt;
         bus_valid  <= valid_nxt;
         bus_toggle <= tog_nxt;
      end
   end

   assign busy = (state != S_IDLE);

endmodule
